// File: rtl/boolean_propose.sv
// Boolean-variable proposal stage: registers the current assignment with exactly
// one selected variable inverted, plus a one-cycle valid strobe per proposal.
module boolean_propose #(
  parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX = 2
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic                                        in_enable,
  input  logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] in_current_assignment_boolean,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_variable_to_be_changed_index,
  output logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] out_new_assignment_Boolean,
  output logic                                        out_valid
);

  localparam int unsigned IdxW   = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int unsigned NumVar = 2 ** IdxW;

  logic [NumVar-1:0] flip_mask;
  logic [NumVar-1:0] proposal_d;
  logic [NumVar-1:0] proposal_q;
  logic              valid_q;

  // One-hot decode of the selected index; the index width covers every variable exactly.
  for (genvar k = 0; k < NumVar; k++) begin : g_decode
    assign flip_mask[k] = (in_variable_to_be_changed_index == IdxW'(k));
  end

  always_comb begin
    proposal_d = in_current_assignment_boolean ^ flip_mask;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      proposal_q <= '0;
      valid_q    <= 1'b0;
    end else if (in_enable) begin
      proposal_q <= proposal_d;
      valid_q    <= 1'b1;
    end else begin
      valid_q    <= 1'b0;
    end
  end

  assign out_new_assignment_Boolean = proposal_q;
  assign out_valid                  = valid_q;

endmodule

// File: tb/tb_boolean_propose.sv
// Self-checking bench for boolean_propose (default N=4): expected output/valid pairs
// are queued as each cycle's stimulus is driven and popped after the clock edge.
module tb_boolean_propose;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] cur;
  logic [1:0] idx;
  logic [3:0] out;
  logic       valid;

  typedef struct packed {
    logic [3:0] out;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  boolean_propose #(
    .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(2)
  ) dut (
    .in_clock                        (clk),
    .in_reset                        (rst),
    .in_enable                       (en),
    .in_current_assignment_boolean   (cur),
    .in_variable_to_be_changed_index (idx),
    .out_new_assignment_Boolean      (out),
    .out_valid                       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge, queue what must appear after the
  // next rising edge, then return 1 time unit past that edge.
  task automatic drive(input logic r, input logic e, input logic [3:0] c, input logic [1:0] i,
                       input logic [3:0] exp_out, input logic exp_valid);
    exp_t item;
    @(negedge clk);
    rst = r;
    en  = e;
    cur = c;
    idx = i;
    item.out   = exp_out;
    item.valid = exp_valid;
    sb.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 1'b1, 4'b1111, 2'd2, 4'b0000, 1'b0);
      e = sb.pop_front();
      tests++;
      if (out !== e.out || valid !== e.valid) begin
        fails++;
        $display("FAIL reset[%0d]: got out=%b valid=%b, need out=%b valid=%b",
                 n, out, valid, e.out, e.valid);
      end
    end
  endtask

  task automatic test_walking;
    exp_t e;
    logic [3:0] walk_exp [4];
    walk_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b1, 4'b0000, 2'(n), walk_exp[n], 1'b1);
      e = sb.pop_front();
      tests++;
      if (out !== e.out || valid !== e.valid) begin
        fails++;
        $display("FAIL walking idx=%0d: got out=%b valid=%b, need out=%b valid=%b",
                 n, out, valid, e.out, e.valid);
      end
    end
  endtask

  task automatic test_patterns;
    exp_t e;
    logic [3:0] p_cur [4];
    logic [1:0] p_idx [4];
    logic [3:0] p_exp [4];
    p_cur = '{4'b1111, 4'b1111, 4'b1010, 4'b1010};
    p_idx = '{2'd3, 2'd0, 2'd1, 2'd2};
    p_exp = '{4'b0111, 4'b1110, 4'b1000, 4'b1110};
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b1, p_cur[n], p_idx[n], p_exp[n], 1'b1);
      e = sb.pop_front();
      tests++;
      if (out !== e.out || valid !== e.valid) begin
        fails++;
        $display("FAIL pattern cur=%b idx=%0d: got out=%b valid=%b, need out=%b valid=%b",
                 p_cur[n], p_idx[n], out, valid, e.out, e.valid);
      end
    end
  endtask

  task automatic test_enable_low;
    exp_t e;
    drive(1'b0, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b1);
    e = sb.pop_front();
    tests++;
    if (out !== e.out || valid !== e.valid) begin
      fails++;
      $display("FAIL enable_low setup: got out=%b valid=%b, need out=%b valid=%b",
               out, valid, e.out, e.valid);
    end
    for (int n = 0; n < 3; n++) begin
      // A mid-cycle enable pulse away from any rising edge must be ignored.
      #1 en = 1'b1; cur = 4'b1100; idx = 2'd1;
      #1 en = 1'b0;
      drive(1'b0, 1'b0, 4'(4'b1111 - n), 2'(3 - n), 4'b0001, 1'b0);
      e = sb.pop_front();
      tests++;
      if (out !== e.out || valid !== e.valid) begin
        fails++;
        $display("FAIL enable_low hold[%0d]: got out=%b valid=%b, need out=%b valid=%b",
                 n, out, valid, e.out, e.valid);
      end
    end
    drive(1'b0, 1'b1, 4'b0100, 2'd0, 4'b0101, 1'b1);
    e = sb.pop_front();
    tests++;
    if (out !== e.out || valid !== e.valid) begin
      fails++;
      $display("FAIL enable_low resume: got out=%b valid=%b, need out=%b valid=%b",
               out, valid, e.out, e.valid);
    end
  endtask

  task automatic test_reset_priority;
    exp_t e;
    drive(1'b1, 1'b1, 4'b0101, 2'd1, 4'b0000, 1'b0);
    e = sb.pop_front();
    tests++;
    if (out !== e.out || valid !== e.valid) begin
      fails++;
      $display("FAIL reset_priority: got out=%b valid=%b, need out=%b valid=%b",
               out, valid, e.out, e.valid);
    end
    drive(1'b0, 1'b1, 4'b0101, 2'd1, 4'b0111, 1'b1);
    e = sb.pop_front();
    tests++;
    if (out !== e.out || valid !== e.valid) begin
      fails++;
      $display("FAIL reset_release: got out=%b valid=%b, need out=%b valid=%b",
               out, valid, e.out, e.valid);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [3:0] c;
    logic [1:0] i;
    logic [3:0] mask;
    for (int n = 0; n < 16; n++) begin
      c = 4'($urandom_range(0, 15));
      i = 2'($urandom_range(0, 3));
      mask = 4'b0001 << i;
      drive(1'b0, 1'b1, c, i, c ^ mask, 1'b1);
      e = sb.pop_front();
      tests++;
      if (out !== e.out || valid !== e.valid || $countones(out ^ c) != 1) begin
        fails++;
        $display("FAIL back_to_back cur=%b idx=%0d: got out=%b valid=%b, need out=%b valid=%b",
                 c, i, out, valid, e.out, e.valid);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    en    = 1'b0;
    cur   = 4'b0000;
    idx   = 2'd0;
    test_reset();
    test_walking();
    test_patterns();
    test_enable_low();
    test_reset_priority();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, need 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boolean_propose.md
Name: boolean_propose

Overview:
Boolean-variable proposal stage of the MCMC constraint solver. Takes the current assignment vector of all Boolean variables and the index of one variable chosen for a move. Produces a registered proposed assignment equal to the current assignment with exactly that one bit inverted. Sits between the variable-selection logic and the constraint-evaluation/accept stage.

Parameters:
MAX_BIT_WIDTH_OF_VARIABLES_INDEX, default 2, width of the variable index. Number of Boolean variables N = 2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX (default N=4).

Ports:
in_clock  input  1  system clock; all state updates on rising edge
in_reset  input  1  synchronous, active-high reset
in_enable  input  1  when high, register a new proposal this cycle
in_current_assignment_boolean  input  N  current value of each Boolean variable; bit i = variable i
in_variable_to_be_changed_index  input  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  index of variable to flip (unsigned)
out_new_assignment_Boolean  output  N  registered proposed assignment
out_valid  output  1  registered; high for one cycle per accepted proposal

Interface decision: one clock; reset is synchronous and active-high (in_clock, in_reset).

Behaviour:
- All outputs are registers updated only on the rising edge of in_clock. No combinational input-to-output path.
- Reset (in_reset=1 at a rising edge):
  - out_new_assignment_Boolean <= 0.
  - out_valid <= 0.
  - Reset has priority over in_enable.
- Enabled cycle (in_reset=0, in_enable=1):
  - out_new_assignment_Boolean <= in_current_assignment_boolean XOR (1 << in_variable_to_be_changed_index).
  - Bit k: inverted when k == index, otherwise copied unchanged.
  - out_valid <= 1.
- Idle cycle (in_reset=0, in_enable=0):
  - out_new_assignment_Boolean holds its previous value.
  - out_valid <= 0.
- Latency: exactly 1 cycle from sampled inputs to output. Back-to-back enabled cycles give one new proposal per cycle.
- Index range: index width covers 0..N-1 exactly, so no out-of-range case exists and no clamping is needed.
  - Index 0 flips the LSB; index N-1 flips the MSB.
- Exactly one bit of the output differs from the sampled input on every enabled cycle, for any input pattern, including all-zeros and all-ones.
- Inputs are sampled only at the clock edge. Changes between edges have no effect.
- Reset mid-stream: the proposal being registered at that edge is discarded. The output goes to 0 and valid deasserts on that edge.
- Generate the decode/XOR logic generically for any parameter value ≥ 1.

Test Plan:
- Reset: assert in_reset for 2 cycles with in_enable=1, current=4'b1111, index=2 -> out=4'b0000, out_valid=0 after each edge.
- Walking flip from zero: current=4'b0000, enable=1, index=0,1,2,3 on successive cycles -> out 4'b0001, 4'b0010, 4'b0100, 4'b1000, each one cycle after its index is applied; out_valid=1 throughout.
- Flip from ones: current=4'b1111, index=3 -> out=4'b0111; index=0 -> out=4'b1110.
- Mixed pattern: current=4'b1010, index=1 -> out=4'b1000; index=2 -> out=4'b1110.
- Enable low: after out=4'b0001, drop in_enable and change current/index -> out stays 4'b0001, out_valid=0, until enable returns.
- Reset priority: in_reset=1 and in_enable=1 in the same cycle with current=4'b0101, index=1 -> out=4'b0000, out_valid=0; next cycle with reset low -> out=4'b0111, out_valid=1.
